id_ex_pipe_stage: RTL and testbench

//  Parametrised ID->EX pipeline stage register with valid/ready flow control.

---
 rtl/id_ex_pipe_stage.sv | 131 +++++++++++++
 tb/tb_id_ex_pipe_stage.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline stage register with valid/ready flow control, flush and an
// optional two-entry skid buffer. Payload fields pass through unmodified.
module id_ex_pipe_stage #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned FUNC_W = 4,
   parameter int unsigned OFF_W  = 8,
   parameter int unsigned REG_W  = 4,
   parameter bit          SKID   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_ctrl,
   input  logic [DATA_W-1:0] in_data1,
   input  logic [DATA_W-1:0] in_data2,
   input  logic [FUNC_W-1:0] in_func,
   input  logic [OFF_W-1:0]  in_offset,
   input  logic [REG_W-1:0]  in_op1,
   input  logic [REG_W-1:0]  in_op2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_ctrl,
   output logic [DATA_W-1:0] out_data1,
   output logic [DATA_W-1:0] out_data2,
   output logic [FUNC_W-1:0] out_func,
   output logic [OFF_W-1:0]  out_offset,
   output logic [REG_W-1:0]  out_op1,
   output logic [REG_W-1:0]  out_op2
);

   localparam int unsigned PAY_W = 8 + 2 * DATA_W + FUNC_W + OFF_W + 2 * REG_W;

   // Occupancy: StOne = main register full, StTwo = main and skid registers full.
   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   state_e           r_state;
   state_e           w_state_next;
   logic [PAY_W-1:0] w_in_pay;
   logic [PAY_W-1:0] r_m_pay;
   logic [PAY_W-1:0] r_s_pay;
   logic             w_in_fire;
   logic             w_out_fire;
   logic             w_out_valid;
   logic             w_load_m;
   logic             w_load_s;
   logic             w_m_from_s;

   // ctrl sits in the top byte so a flush can clear it alone.
   assign w_in_pay = {in_ctrl, in_data1, in_data2, in_func, in_offset, in_op1, in_op2};

   assign w_out_valid = (r_state != StEmpty);
   // With the skid buffer, ready depends only on state, so there is no ready path
   // from out_ready back to in_ready.
   assign in_ready    = SKID ? (r_state != StTwo) : (!w_out_valid || out_ready);
   assign w_in_fire   = in_valid & in_ready;
   assign w_out_fire  = w_out_valid & out_ready;

   // Next-state and register load decode; flush overrides every transfer.
   always_comb begin
      w_state_next = r_state;
      w_load_m     = 1'b0;
      w_load_s     = 1'b0;
      w_m_from_s   = 1'b0;
      case (r_state)
         StEmpty: begin
            if (w_in_fire) begin
               w_load_m     = 1'b1;
               w_state_next = StOne;
            end
         end
         StOne: begin
            // Without a skid register an accept while full only happens on out_fire.
            if (w_in_fire && (w_out_fire || !SKID)) begin
               w_load_m = 1'b1;
            end else if (w_in_fire) begin
               w_load_s     = 1'b1;
               w_state_next = StTwo;
            end else if (w_out_fire) begin
               w_state_next = StEmpty;
            end
         end
         StTwo: begin
            if (w_out_fire) begin
               w_m_from_s   = 1'b1;
               w_state_next = StOne;
            end
         end
         default: w_state_next = StEmpty;
      endcase
      if (flush) begin
         w_state_next = StEmpty;
         w_load_m     = 1'b0;
         w_load_s     = 1'b0;
         w_m_from_s   = 1'b0;
      end
   end

   // Occupancy state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StEmpty;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Main and skid payload registers; flush zeroes only ctrl so no write leaks.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_pay <= '0;
         r_s_pay <= '0;
      end else begin
         if (flush) begin
            r_m_pay[PAY_W-1 -: 8] <= 8'd0;
         end else if (w_load_m) begin
            r_m_pay <= w_in_pay;
         end else if (w_m_from_s) begin
            r_m_pay <= r_s_pay;
         end
         if (w_load_s) begin
            r_s_pay <= w_in_pay;
         end
      end
   end

   assign out_valid = w_out_valid;
   assign {out_ctrl, out_data1, out_data2, out_func, out_offset, out_op1, out_op2} = r_m_pay;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage: one SKID=1 and one SKID=0 instance, each exercised
// in turn against a queue model of the stage (bounded FIFO of capacity 2 or 1).
module tb_id_ex_pipe_stage;

   typedef struct packed {
      logic [7:0]  ctrl;
      logic [15:0] d1;
      logic [15:0] d2;
      logic [3:0]  func;
      logic [7:0]  off;
      logic [3:0]  op1;
      logic [3:0]  op2;
   } pay_t;

   logic        clk = 1'b0;
   logic        rst       [2];
   logic        flush     [2];
   logic        in_valid  [2];
   logic        out_ready [2];
   logic        in_ready  [2];
   logic        out_valid [2];
   pay_t        in_p      [2];
   logic [7:0]  o_ctrl    [2];
   logic [15:0] o_d1      [2];
   logic [15:0] o_d2      [2];
   logic [3:0]  o_func    [2];
   logic [7:0]  o_off     [2];
   logic [3:0]  o_op1     [2];
   logic [3:0]  o_op2     [2];

   int   cur;
   int   n_vec;
   int   n_err;
   pay_t q[$];

   always #5 clk = ~clk;

   id_ex_pipe_stage #(.DATA_W(16), .FUNC_W(4), .OFF_W(8), .REG_W(4), .SKID(1'b1)) u_skid (
      .clk(clk), .rst(rst[0]), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_ctrl(in_p[0].ctrl), .in_data1(in_p[0].d1), .in_data2(in_p[0].d2),
      .in_func(in_p[0].func), .in_offset(in_p[0].off), .in_op1(in_p[0].op1),
      .in_op2(in_p[0].op2), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_ctrl(o_ctrl[0]), .out_data1(o_d1[0]), .out_data2(o_d2[0]), .out_func(o_func[0]),
      .out_offset(o_off[0]), .out_op1(o_op1[0]), .out_op2(o_op2[0])
   );

   id_ex_pipe_stage #(.DATA_W(16), .FUNC_W(4), .OFF_W(8), .REG_W(4), .SKID(1'b0)) u_noskid (
      .clk(clk), .rst(rst[1]), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_ctrl(in_p[1].ctrl), .in_data1(in_p[1].d1), .in_data2(in_p[1].d2),
      .in_func(in_p[1].func), .in_offset(in_p[1].off), .in_op1(in_p[1].op1),
      .in_op2(in_p[1].op2), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_ctrl(o_ctrl[1]), .out_data1(o_d1[1]), .out_data2(o_d2[1]), .out_func(o_func[1]),
      .out_offset(o_off[1]), .out_op1(o_op1[1]), .out_op2(o_op2[1])
   );

   function automatic pay_t dut_out();
      pay_t p;
      p = {o_ctrl[cur], o_d1[cur], o_d2[cur], o_func[cur], o_off[cur], o_op1[cur], o_op2[cur]};
      return p;
   endfunction

   // Model acceptance: skid instance holds two entries, plain one holds one but can
   // swap its entry in the same cycle the consumer takes it.
   function automatic logic mdl_ready();
      if (cur == 0) return (q.size() < 2);
      return (q.size() == 0) || out_ready[cur];
   endfunction

   task automatic drive(input logic v, input logic [15:0] d1, input logic [7:0] ctrl,
                        input logic ordy, input logic fl);
      pay_t p;
      p.ctrl = ctrl;
      p.d1   = d1;
      p.d2   = 16'($urandom);
      p.func = 4'($urandom);
      p.off  = 8'($urandom);
      p.op1  = 4'($urandom);
      p.op2  = 4'($urandom);
      in_p[cur]      = p;
      in_valid[cur]  = v;
      out_ready[cur] = ordy;
      flush[cur]     = fl;
   endtask

   // Advance one clock and update the model with the inputs seen at the edge.
   task automatic tick();
      logic rdy;
      logic in_fire;
      logic out_fire;
      @(posedge clk);
      rdy      = mdl_ready();
      in_fire  = in_valid[cur] && rdy;
      out_fire = (q.size() > 0) && out_ready[cur];
      if (rst[cur] || flush[cur]) begin
         q.delete();
      end else begin
         if (out_fire) void'(q.pop_front());
         if (in_fire) q.push_back(in_p[cur]);
      end
      #1;
   endtask

   task automatic test_reset();
      rst[cur] = 1'b1;
      drive(1'b1, 16'hBEEF, 8'hFF, 1'b0, 1'b1);
      tick();
      rst[cur] = 1'b0;
      drive(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      @(negedge clk);
      n_vec++;
      if (out_valid[cur] !== 1'b0) begin
         n_err++; $display("FAIL reset_valid dut%0d: got %b want 0", cur, out_valid[cur]);
      end
      n_vec++;
      if (o_ctrl[cur] !== 8'h00) begin
         n_err++; $display("FAIL reset_ctrl dut%0d: got %h want 00", cur, o_ctrl[cur]);
      end
      n_vec++;
      if (o_d1[cur] !== 16'h0000) begin
         n_err++; $display("FAIL reset_data1 dut%0d: got %h want 0000", cur, o_d1[cur]);
      end
      n_vec++;
      if (in_ready[cur] !== 1'b1) begin
         n_err++; $display("FAIL reset_ready dut%0d: got %b want 1", cur, in_ready[cur]);
      end
      tick();
   endtask

   task automatic test_streaming();
      for (int k = 1; k <= 10; k++) begin
         if (k <= 8) drive(1'b1, 16'(k), 8'($urandom), 1'b1, 1'b0);
         else drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
         @(negedge clk);
         n_vec++;
         if (out_valid[cur] !== (q.size() > 0)) begin
            n_err++;
            $display("FAIL stream_valid dut%0d k%0d: got %b want %b", cur, k, out_valid[cur],
                     q.size() > 0);
         end
         n_vec++;
         if (in_ready[cur] !== mdl_ready()) begin
            n_err++;
            $display("FAIL stream_ready dut%0d k%0d: got %b want %b", cur, k, in_ready[cur],
                     mdl_ready());
         end
         if (q.size() > 0) begin
            n_vec++;
            if (dut_out() !== q[0]) begin
               n_err++;
               $display("FAIL stream_payload dut%0d k%0d: got %h want %h", cur, k, dut_out(), q[0]);
            end
         end
         // One-cycle lag, no bubbles: cycle k shows item k-1.
         if (k >= 2 && k <= 9) begin
            n_vec++;
            if (out_valid[cur] !== 1'b1 || o_d1[cur] !== 16'(k - 1)) begin
               n_err++;
               $display("FAIL stream_seq dut%0d k%0d: got v%b d%h want v1 d%h", cur, k,
                        out_valid[cur], o_d1[cur], 16'(k - 1));
            end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] items [3];
      logic [15:0] got[$];
      int          idx;
      logic        ordy;
      items[0] = 16'h000A;
      items[1] = 16'h000B;
      items[2] = 16'h000C;
      idx = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         ordy = (cyc == 0) || (cyc >= 4);
         if (idx < 3) drive(1'b1, items[idx], 8'($urandom), ordy, 1'b0);
         else drive(1'b0, 16'h0, 8'h0, ordy, 1'b0);
         @(negedge clk);
         n_vec++;
         if (out_valid[cur] !== (q.size() > 0) || in_ready[cur] !== mdl_ready()) begin
            n_err++;
            $display("FAIL bp_flow dut%0d c%0d: got v%b r%b want v%b r%b", cur, cyc,
                     out_valid[cur], in_ready[cur], q.size() > 0, mdl_ready());
         end
         if (q.size() > 0) begin
            n_vec++;
            if (dut_out() !== q[0]) begin
               n_err++;
               $display("FAIL bp_payload dut%0d c%0d: got %h want %h", cur, cyc, dut_out(), q[0]);
            end
         end
         if (cyc == 3) begin
            n_vec++;
            if (in_ready[cur] !== 1'b0 || out_valid[cur] !== 1'b1 || o_d1[cur] !== 16'h000A) begin
               n_err++;
               $display("FAIL bp_stall dut%0d: got r%b v%b d%h want r0 v1 d000a", cur,
                        in_ready[cur], out_valid[cur], o_d1[cur]);
            end
         end
         if (out_valid[cur] === 1'b1 && ordy) got.push_back(o_d1[cur]);
         if (idx < 3 && mdl_ready()) idx++;
         tick();
      end
      n_vec++;
      if (got.size() != 3 || idx != 3) begin
         n_err++;
         $display("FAIL bp_count dut%0d: got %0d out %0d in want 3 3", cur, got.size(), idx);
      end else if (got[0] !== 16'h000A || got[1] !== 16'h000B || got[2] !== 16'h000C) begin
         n_err++;
         $display("FAIL bp_order dut%0d: got %h %h %h want 000a 000b 000c", cur, got[0], got[1],
                  got[2]);
      end
   endtask

   task automatic test_flush();
      drive(1'b1, 16'h0001, 8'hFF, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'h0002, 8'hFF, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'h000D, 8'hFF, 1'b0, 1'b1);
      @(negedge clk);
      n_vec++;
      if (in_ready[cur] !== mdl_ready()) begin
         n_err++;
         $display("FAIL flush_pre_ready dut%0d: got %b want %b", cur, in_ready[cur], mdl_ready());
      end
      tick();
      for (int c = 0; c < 4; c++) begin
         drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
         @(negedge clk);
         n_vec++;
         if (out_valid[cur] !== 1'b0 || o_ctrl[cur] !== 8'h00) begin
            n_err++;
            $display("FAIL flush_kill dut%0d c%0d: got v%b ctrl%h want v0 ctrl00", cur, c,
                     out_valid[cur], o_ctrl[cur]);
         end
         n_vec++;
         if (in_ready[cur] !== 1'b1) begin
            n_err++; $display("FAIL flush_ready dut%0d c%0d: got %b want 1", cur, c, in_ready[cur]);
         end
         tick();
      end
   endtask

   task automatic test_ctrl_random();
      for (int c = 0; c < 300; c++) begin
         if (c < 295) drive(($urandom % 4) != 0, 16'($urandom), 8'b11_101_10_1,
                            ($urandom % 3) != 0, 1'b0);
         else drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
         @(negedge clk);
         n_vec++;
         if (out_valid[cur] !== (q.size() > 0) || in_ready[cur] !== mdl_ready()) begin
            n_err++;
            $display("FAIL rnd_flow dut%0d c%0d: got v%b r%b want v%b r%b", cur, c,
                     out_valid[cur], in_ready[cur], q.size() > 0, mdl_ready());
         end
         if (q.size() > 0) begin
            n_vec++;
            if (dut_out() !== q[0]) begin
               n_err++;
               $display("FAIL rnd_payload dut%0d c%0d: got %h want %h", cur, c, dut_out(), q[0]);
            end
            if (out_ready[cur]) begin
               n_vec++;
               if (o_ctrl[cur] !== 8'b11_101_10_1) begin
                  n_err++;
                  $display("FAIL rnd_ctrl dut%0d c%0d: got %b want 11101101", cur, c, o_ctrl[cur]);
               end
            end
         end
         tick();
      end
   endtask

   // Plain stage: in_ready must follow out_ready within the cycle while full.
   task automatic test_comb_ready();
      drive(1'b1, 16'h0055, 8'h11, 1'b0, 1'b0);
      tick();
      in_valid[cur] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         out_ready[cur] = i[0];
         #1;
         n_vec++;
         if (in_ready[cur] !== i[0]) begin
            n_err++;
            $display("FAIL comb_ready i%0d: got %b want %b", i, in_ready[cur], i[0]);
         end
      end
      drive(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
      tick();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      for (int i = 0; i < 2; i++) begin
         rst[i]       = 1'b0;
         flush[i]     = 1'b0;
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b0;
         in_p[i]      = '0;
      end
      for (int d = 0; d < 2; d++) begin
         cur = d;
         q.delete();
         test_reset();
         test_streaming();
         test_backpressure();
         test_flush();
         test_ctrl_random();
         if (d == 1) test_comb_ready();
         drive(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
